sdp_ram2048x8: RTL and testbench

Simple dual-port synchronous RAM, 2048 words x 8 bits, on one clock: one write-only port and one read-only port. The read path goes through the array's synchronous read register and an optional output register. It serves as a line or character buffer in the UDP/OSD video path, where one agent fills the buffer and another reads it back. Reset clears only the read pipeline, never the storage array.

---
 rtl/sdp_ram_pkg.sv | 11 +
 rtl/sdp_ram_array.sv | 49 ++++
 rtl/sdp_ram2048x8.sv | 72 +++++++
 tb/tb_sdp_ram2048x8.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared defaults and constants for the simple dual-port RAM.
package sdp_ram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 11;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;

  // Value the read pipeline takes while reset is asserted.
  localparam logic [DEF_DATA_WIDTH-1:0] RD_RST_VAL = '0;

endpackage

// File: rtl/sdp_ram_array.sv
// Storage array with write port and stage-1 synchronous read register.
// The array itself is never reset; only the read register is.
module sdp_ram_array
  import sdp_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_q1_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_q1_d, rd_q1_q;

  // Writes ignore reset so a fill in progress is never lost.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-first: the array read sees contents before this edge's write.
  always_comb begin
    rd_q1_d = rd_q1_q;
    if (rd_en_i) begin
      rd_q1_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q1_q <= DATA_WIDTH'(RD_RST_VAL);
    end else begin
      rd_q1_q <= rd_q1_d;
    end
  end

  assign rd_q1_o = rd_q1_q;

endmodule

// File: rtl/sdp_ram2048x8.sv
// 2048x8 simple dual-port RAM: one write port, one read port, optional output register.
// Define SDP_RAM_RD_OCE_EN to add rd_oce_i, a clock enable for the last read register.
module sdp_ram2048x8
  import sdp_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUTPUT_REG = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
`ifdef SDP_RAM_RD_OCE_EN
  input  logic                  rd_oce_i,
`endif
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic                  rd_oce;
  logic                  rd_q1_en;
  logic [DATA_WIDTH-1:0] rd_q1;

`ifdef SDP_RAM_RD_OCE_EN
  assign rd_oce = rd_oce_i;
`else
  assign rd_oce = 1'b1;
`endif

  // The enable always gates whichever register drives rd_data_o.
  assign rd_q1_en = (OUTPUT_REG != 0) ? 1'b1 : rd_oce;

  sdp_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_en_i   (rd_q1_en),
    .rd_q1_o   (rd_q1)
  );

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_q2_d, rd_q2_q;

    always_comb begin
      rd_q2_d = rd_q2_q;
      if (rd_oce) begin
        rd_q2_d = rd_q1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_q2_q <= DATA_WIDTH'(RD_RST_VAL);
      end else begin
        rd_q2_q <= rd_q2_d;
      end
    end

    assign rd_data_o = rd_q2_q;
  end else begin : g_no_out_reg
    assign rd_data_o = rd_q1;
  end

endmodule

// File: tb/tb_sdp_ram2048x8.sv
// Directed bench: one instance with the output register, one without, sharing stimulus.
module tb_sdp_ram2048x8;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data_r1;
  logic [7:0]  rd_data_r0;
  logic        oce1;
  logic        oce0;

  int total = 0;
  int bad   = 0;

  sdp_ram2048x8 #(.OUTPUT_REG(1)) dut_r1 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
`ifdef SDP_RAM_RD_OCE_EN
    .rd_oce_i  (oce1),
`endif
    .rd_data_o (rd_data_r1)
  );

  sdp_ram2048x8 #(.OUTPUT_REG(0)) dut_r0 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
`ifdef SDP_RAM_RD_OCE_EN
    .rd_oce_i  (oce0),
`endif
    .rd_data_o (rd_data_r0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sweep_val(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    return 8'hFF - lo;
  endfunction

  initial begin
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    oce1    = 1'b1;
    oce0    = 1'b1;

    // Reset held for 20 cycles.
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_hold_r1", rd_data_r1, 8'h00);
      check("rst_hold_r0", rd_data_r0, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_r1", rd_data_r1, 8'h00);
    check("post_rst_r0", rd_data_r0, 8'h00);

    // Fill the whole array.
    for (int a = 0; a < 2048; a++) begin
      wr_en   = 1'b1;
      wr_addr = 11'(a);
      wr_data = sweep_val(a);
      tick();
    end
    wr_en = 1'b0;

    // Back-to-back read sweep; r0 shows address i after tick i, r1 one tick later.
    for (int i = 0; i < 2049; i++) begin
      if (i < 2048) rd_addr = 11'(i);
      tick();
      if (i < 2048) check("sweep_r0", rd_data_r0, sweep_val(i));
      if (i >= 1)   check("sweep_r1", rd_data_r1, sweep_val(i - 1));
    end

    // Latency: write 0xA5 to 5, then read it.
    wr_en = 1'b1; wr_addr = 11'd5; wr_data = 8'hA5; rd_addr = 11'd6;
    tick();
    wr_en = 1'b0; rd_addr = 11'd5;
    tick();
    check("lat_r0", rd_data_r0, 8'hA5);
    check("lat_r1_prev", rd_data_r1, sweep_val(6));
    tick();
    check("lat_r1", rd_data_r1, 8'hA5);

    // wr_en low must not write.
    wr_en = 1'b0; wr_addr = 11'd300; wr_data = 8'h00; rd_addr = 11'd300;
    tick();
    check("no_write_r0", rd_data_r0, 8'hD3);

    // Independent read and write to different addresses on the same edge.
    wr_en = 1'b1; wr_addr = 11'd200; wr_data = 8'h5C; rd_addr = 11'd201;
    tick();
    check("diff_addr_r0", rd_data_r0, 8'h36);
    wr_en = 1'b0; rd_addr = 11'd200;
    tick();
    check("diff_addr_wr_r0", rd_data_r0, 8'h5C);

    // Read-during-write is read-first.
    wr_en = 1'b1; wr_addr = 11'd7; wr_data = 8'h11;
    tick();
    wr_data = 8'h22; rd_addr = 11'd7;
    tick();
    check("rdw_old_r0", rd_data_r0, 8'h11);
    wr_en = 1'b0;
    tick();
    check("rdw_new_r0", rd_data_r0, 8'h22);
    check("rdw_old_r1", rd_data_r1, 8'h11);
    tick();
    check("rdw_new_r1", rd_data_r1, 8'h22);

    // Asynchronous reset in the middle of a sweep; a write during reset still lands.
    for (int i = 90; i < 95; i++) begin
      rd_addr = 11'(i);
      tick();
    end
    check("pre_rst_r1", rd_data_r1, sweep_val(93));
    #4 rst_n = 1'b0;
    #1;
    check("async_rst_r1", rd_data_r1, 8'h00);
    check("async_rst_r0", rd_data_r0, 8'h00);
    wr_en = 1'b1; wr_addr = 11'd50; wr_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      rd_addr = 11'(95 + i);
      tick();
      wr_en = 1'b0;
      check("rst_mid_r1", rd_data_r1, 8'h00);
      check("rst_mid_r0", rd_data_r0, 8'h00);
    end
    rst_n   = 1'b1;
    rd_addr = 11'd100;
    tick();
    check("keep100_r0", rd_data_r0, 8'h9B);
    rd_addr = 11'd50;
    tick();
    check("keep100_r1", rd_data_r1, 8'h9B);
    check("wr_in_rst_r0", rd_data_r0, 8'h5A);

`ifdef SDP_RAM_RD_OCE_EN
    // Output clock enable holds the last read register.
    wr_en = 1'b1; wr_addr = 11'd1; wr_data = 8'h01;
    tick();
    wr_addr = 11'd2; wr_data = 8'h02;
    tick();
    wr_en = 1'b0; rd_addr = 11'd1;
    tick();
    check("oce_a1_r0", rd_data_r0, 8'h01);
    rd_addr = 11'd2; oce0 = 1'b0;
    tick();
    check("oce_hold_r0", rd_data_r0, 8'h01);
    check("oce_a1_r1", rd_data_r1, 8'h01);
    oce0 = 1'b1; oce1 = 1'b0;
    tick();
    check("oce_rel_r0", rd_data_r0, 8'h02);
    check("oce_hold_r1", rd_data_r1, 8'h01);
    oce1 = 1'b1;
    tick();
    check("oce_rel_r1", rd_data_r1, 8'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
